// File: rtl/grf_sb_multiport_pkg.sv
// Shared constants and helpers for the multiport general register file with
// a pending-write scoreboard.
package grf_sb_multiport_pkg;

    localparam int unsigned DefDataW = 32;
    localparam int unsigned DefAddrW = 5;
    localparam int unsigned ZeroReg  = 0;

    // time@pc: $reg <= data
    localparam string TraceFmt = "%0t@%h: $%0d <= %h";

    // LSB of field idx in a packed multi-port bus of width-w fields.
    function automatic int unsigned port_lsb(input int unsigned idx, input int unsigned w);
        return idx * w;
    endfunction

endpackage

// File: rtl/grf_scoreboard.sv
// Per-register pending-write counters for long-latency (port B) writebacks,
// with reservation back-pressure, read-busy status and a sticky underflow flag.
module grf_scoreboard
    import grf_sb_multiport_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned CNT_W  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic                     resv_en,
    input  logic [ADDR_W-1:0]        resv_addr,
    output logic                     resv_ready,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic                     err_underflow
);

    localparam int unsigned Depth = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] Zero = ADDR_W'(ZeroReg);
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [CNT_W-1:0] cnt_q [Depth];
    logic [CNT_W-1:0] cnt_d [Depth];
    logic             err_q, err_d;
    logic             resv_inc, wb_dec;

    always_comb begin
        resv_ready = (resv_addr == Zero) || (cnt_q[resv_addr] != CntMax);
        resv_inc   = resv_en && resv_ready && (resv_addr != Zero);
        wb_dec     = wb_en && (wb_addr != Zero);
    end

    // A reservation and a retirement on the same register cancel out.
    always_comb begin
        err_d = err_q;
        for (int r = 0; r < Depth; r++) begin
            cnt_d[r] = cnt_q[r];
            if (resv_inc && (resv_addr == ADDR_W'(r)) &&
                !(wb_dec && (wb_addr == ADDR_W'(r)))) begin
                cnt_d[r] = cnt_q[r] + CNT_W'(1);
            end else if (wb_dec && (wb_addr == ADDR_W'(r)) &&
                         !(resv_inc && (resv_addr == ADDR_W'(r)))) begin
                if (cnt_q[r] == '0) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < Depth; r++) begin
                cnt_q[r] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int r = 0; r < Depth; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            err_q <= err_d;
        end
    end

    // The last pending write landing this cycle is forwarded, so it is not busy.
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            logic [ADDR_W-1:0] a;
            a = rd_addr[port_lsb(i, ADDR_W) +: ADDR_W];
            rd_busy[i] = (a != Zero) && (cnt_q[a] != '0) &&
                         !((cnt_q[a] == CNT_W'(1)) && wb_dec && (wb_addr == a) &&
                           !(resv_inc && (resv_addr == a)));
        end
    end

    assign err_underflow = err_q;

endmodule

// File: rtl/grf_sb_multiport.sv
// Parametrised general register file: NUM_RD forwarding read ports, in-order
// write port A, long-latency write port B and a pending-write scoreboard.
module grf_sb_multiport
    import grf_sb_multiport_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned CNT_W  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wa_en,
    input  logic [ADDR_W-1:0]        wa_addr,
    input  logic [DATA_W-1:0]        wa_data,
    input  logic [31:0]              wa_pc,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic [31:0]              wb_pc,
    input  logic                     resv_en,
    input  logic [ADDR_W-1:0]        resv_addr,
    output logic                     resv_ready,
    output logic                     err_underflow
);

    localparam int unsigned Depth = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] Zero = ADDR_W'(ZeroReg);

    logic [DATA_W-1:0] regs_q [Depth];
    logic              wa_commit, wb_commit;

    assign wa_commit = wa_en && (wa_addr != Zero);
    assign wb_commit = wb_en && (wb_addr != Zero);

    // Port A is the younger instruction, so its write lands last.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < Depth; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            if (wb_commit) begin
                regs_q[wb_addr] <= wb_data;
            end
            if (wa_commit) begin
                regs_q[wa_addr] <= wa_data;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            logic [ADDR_W-1:0] a;
            a = rd_addr[port_lsb(i, ADDR_W) +: ADDR_W];
            if (a == Zero) begin
                rd_data[port_lsb(i, DATA_W) +: DATA_W] = '0;
            end else if (wa_en && (wa_addr == a)) begin
                rd_data[port_lsb(i, DATA_W) +: DATA_W] = wa_data;
            end else if (wb_en && (wb_addr == a)) begin
                rd_data[port_lsb(i, DATA_W) +: DATA_W] = wb_data;
            end else begin
                rd_data[port_lsb(i, DATA_W) +: DATA_W] = regs_q[a];
            end
        end
    end

    grf_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD),
        .CNT_W  (CNT_W)
    ) u_scoreboard (
        .clk           (clk),
        .reset         (reset),
        .rd_addr       (rd_addr),
        .wb_en         (wb_en),
        .wb_addr       (wb_addr),
        .resv_en       (resv_en),
        .resv_addr     (resv_addr),
        .resv_ready    (resv_ready),
        .rd_busy       (rd_busy),
        .err_underflow (err_underflow)
    );

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (wb_commit) begin
                $display(TraceFmt, $time, wb_pc, wb_addr, wb_data);
            end
            if (wa_commit) begin
                $display(TraceFmt, $time, wa_pc, wa_addr, wa_data);
            end
        end
    end
`endif

endmodule

// File: tb/tb_grf_sb_multiport.sv
// Directed and randomized checks of grf_sb_multiport against an event-level
// model of the register file and its reservation counters.
module tb_grf_sb_multiport;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int MaxCnt = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0] rd_busy;
    logic          wa_en, wb_en, resv_en;
    logic [AW-1:0] wa_addr, wb_addr, resv_addr;
    logic [DW-1:0] wa_data, wb_data;
    logic [31:0]   wa_pc, wb_pc;
    logic          resv_ready, err_underflow;

    grf_sb_multiport #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .NUM_RD (NR),
        .CNT_W  (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_busy       (rd_busy),
        .wa_en         (wa_en),
        .wa_addr       (wa_addr),
        .wa_data       (wa_data),
        .wa_pc         (wa_pc),
        .wb_en         (wb_en),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .wb_pc         (wb_pc),
        .resv_en       (resv_en),
        .resv_addr     (resv_addr),
        .resv_ready    (resv_ready),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [DW-1:0] m_reg [32];
    int            m_cnt [32];
    bit            m_err;
    bit            model_ok = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic bit m_ready();
        return (resv_addr == 0) || (m_cnt[resv_addr] < MaxCnt);
    endfunction

    function automatic logic [DW-1:0] m_read(input int a);
        if (a == 0) return '0;
        if (wa_en && wa_addr == a) return wa_data;
        if (wb_en && wb_addr == a) return wb_data;
        return m_reg[a];
    endfunction

    // Busy unless no write is pending, or the only pending write lands now.
    function automatic bit m_busy(input int a);
        int pending_after;
        if (a == 0) return 1'b0;
        pending_after = m_cnt[a];
        if (wb_en && wb_addr == a) pending_after -= 1;
        if (resv_en && m_ready() && resv_addr == a) pending_after += 1;
        if (m_cnt[a] == 0) return 1'b0;
        return pending_after > 0;
    endfunction

    task automatic m_clock();
        bit take_resv;
        if (reset) begin
            for (int r = 0; r < 32; r++) begin
                m_reg[r] = '0;
                m_cnt[r] = 0;
            end
            m_err = 1'b0;
            model_ok = 1'b1;
            return;
        end
        take_resv = resv_en && m_ready() && resv_addr != 0;
        if (wb_en && wb_addr != 0) m_reg[wb_addr] = wb_data;
        if (wa_en && wa_addr != 0) m_reg[wa_addr] = wa_data;
        if (take_resv && wb_en && wb_addr == resv_addr) begin
            // reservation and retirement of the same register net to zero
        end else begin
            if (take_resv) m_cnt[resv_addr] += 1;
            if (wb_en && wb_addr != 0) begin
                if (m_cnt[wb_addr] == 0) m_err = 1'b1;
                else m_cnt[wb_addr] -= 1;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (model_ok) begin
            for (int i = 0; i < NR; i++) begin
                check($sformatf("rd_data%0d", i), 64'(rd_data[i*DW +: DW]),
                      64'(m_read(int'(rd_addr[i*AW +: AW]))));
                check($sformatf("rd_busy%0d", i), 64'(rd_busy[i]),
                      64'(m_busy(int'(rd_addr[i*AW +: AW]))));
            end
            check("resv_ready", 64'(resv_ready), 64'(m_ready()));
            check("err_underflow", 64'(err_underflow), 64'(m_err));
        end
        @(posedge clk);
        m_clock();
        #1;
    endtask

    task automatic idle();
        reset = 1'b0;
        wa_en = 1'b0; wa_addr = '0; wa_data = '0; wa_pc = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; wb_pc = '0;
        resv_en = 1'b0; resv_addr = '0;
        rd_addr = '0;
    endtask

    task automatic set_rd(input int a0, input int a1);
        rd_addr = {AW'(a1), AW'(a0)};
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick();
        idle();
        set_rd(3, 7);
        tick();

        // Port A write then read on both ports.
        wa_en = 1; wa_addr = 3; wa_data = 32'h1234_5678; wa_pc = 32'h100;
        tick();
        idle(); set_rd(3, 3); #1;
        check("a_wr_p0", 64'(rd_data[31:0]), 64'h1234_5678);
        check("a_wr_p1", 64'(rd_data[63:32]), 64'h1234_5678);
        check("a_wr_busy", 64'(rd_busy), 64'h0);
        tick();

        // Same-cycle A and B to one register: A wins, forwarding picks A.
        wa_en = 1; wa_addr = 5; wa_data = 32'hAAAA; wa_pc = 32'h200;
        wb_en = 1; wb_addr = 5; wb_data = 32'hBBBB; wb_pc = 32'h1F0;
        set_rd(5, 0); #1;
        check("ab_fwd", 64'(rd_data[31:0]), 64'hAAAA);
        tick();
        idle(); set_rd(5, 0); #1;
        check("ab_stored", 64'(rd_data[31:0]), 64'hAAAA);
        check("ab_underflow", 64'(err_underflow), 64'h1);
        tick();
        reset = 1'b1;
        tick();
        idle(); #1;
        check("rst_err_clr", 64'(err_underflow), 64'h0);

        // Reserve, see busy, retire with forwarding.
        resv_en = 1; resv_addr = 8; #1;
        check("resv8_ready", 64'(resv_ready), 64'h1);
        tick();
        idle(); set_rd(8, 0); #1;
        check("resv8_busy", 64'(rd_busy[0]), 64'h1);
        tick();
        wb_en = 1; wb_addr = 8; wb_data = 32'h55; set_rd(8, 0); #1;
        check("wb8_nobusy", 64'(rd_busy[0]), 64'h0);
        check("wb8_fwd", 64'(rd_data[31:0]), 64'h55);
        tick();
        idle(); set_rd(8, 0); tick();

        // Saturate $9, drop a fourth reservation, retire three.
        for (int k = 0; k < 3; k++) begin
            resv_en = 1; resv_addr = 9; tick();
        end
        idle(); resv_addr = 9; #1;
        check("resv9_full", 64'(resv_ready), 64'h0);
        resv_en = 1; tick();
        for (int k = 0; k < 3; k++) begin
            idle(); wb_en = 1; wb_addr = 9; wb_data = 32'(k + 1); tick();
            idle(); set_rd(9, 9); #1;
            check("wb9_busy", 64'(rd_busy[0]), (k < 2) ? 64'h1 : 64'h0);
        end
        tick();

        // Unreserved port-B write, then register-0 accesses.
        wb_en = 1; wb_addr = 10; wb_data = 32'hDEAD; tick();
        idle(); set_rd(10, 0); #1;
        check("uf_data", 64'(rd_data[31:0]), 64'hDEAD);
        check("uf_err", 64'(err_underflow), 64'h1);
        wa_en = 1; wa_addr = 0; wa_data = 32'hFFFF; resv_en = 1; resv_addr = 0;
        set_rd(0, 0); #1;
        check("r0_data", 64'(rd_data), 64'h0);
        check("r0_ready", 64'(resv_ready), 64'h1);
        tick();
        idle(); set_rd(0, 10); #1;
        check("r0_busy", 64'(rd_busy), 64'h0);
        check("uf_sticky", 64'(err_underflow), 64'h1);
        tick();

        // Reset while writes and reservations are requested.
        reset = 1; wa_en = 1; wa_addr = 3; wa_data = 32'hCAFE; resv_en = 1; resv_addr = 4;
        tick();
        idle(); set_rd(3, 4); #1;
        check("rst_data", 64'(rd_data), 64'h0);
        check("rst_busy", 64'(rd_busy), 64'h0);
        check("rst_err", 64'(err_underflow), 64'h0);
        tick();

        // Randomized traffic over a small address window to force collisions.
        for (int n = 0; n < 400; n++) begin
            reset     = ($urandom_range(0, 59) == 0);
            wa_en     = ($urandom_range(0, 2) == 0);
            wa_addr   = AW'($urandom_range(0, 7));
            wa_data   = $urandom;
            wa_pc     = $urandom;
            wb_en     = ($urandom_range(0, 2) == 0);
            wb_addr   = AW'($urandom_range(0, 7));
            wb_data   = $urandom;
            wb_pc     = $urandom;
            resv_en   = ($urandom_range(0, 1) == 0);
            resv_addr = AW'($urandom_range(0, 7));
            set_rd(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/grf_sb_multiport.md
Name: grf_sb_multiport

Overview:
- Parametrised successor to the pipeline general register file (GRF).
- Configurable data width, depth and read-port count; register 0 is hardwired to zero.
- Two write ports: port A is in-order writeback; port B is a long-latency unit (mult/div) writeback.
- Adds write-through forwarding and a per-register pending-write scoreboard, so the hazard unit can stall reads of registers awaiting port B.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports
- CNT_W, 2, pending-write counter width per register; max outstanding = 2**CNT_W-1

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, combinational
- rd_busy  out  NUM_RD  high = register i has an unresolved pending port-B write
- wa_en  in  1  port A write enable
- wa_addr  in  ADDR_W  port A target
- wa_data  in  DATA_W  port A data
- wa_pc  in  32  PC of the instruction writing via A (trace only)
- wb_en  in  1  port B write enable; also retires one reservation
- wb_addr  in  ADDR_W  port B target
- wb_data  in  DATA_W  port B data
- wb_pc  in  32  PC for port B trace
- resv_en  in  1  reserve a future port-B write to resv_addr
- resv_addr  in  ADDR_W  register being reserved
- resv_ready  out  1  resv_addr counter below max (reservation accepted)
- err_underflow  out  1  sticky; a port-B write hit a zero counter

Behaviour:
- Reset (clk edge with reset=1): all registers and counters become 0; err_underflow=0. Writes, reservations and traces are suppressed that cycle.
- After reset: rd_data=0, rd_busy=0, resv_ready=1.
- Register 0:
  - Reads of address 0 always return 0 with busy=0.
  - Writes, reservations and traces to address 0 are ignored.
- Writes commit at the clk edge.
- Same-cycle A and B writes to the same address: A's data is stored (A is the younger instruction in program order). Both trace lines print, B first.
- Read forwarding, per read port, with priority:
  1. address 0 -> 0
  2. wa_en && wa_addr==rd_addr -> wa_data
  3. wb_en && wb_addr==rd_addr -> wb_data
  4. otherwise the stored register
- Scoreboard: per register, one CNT_W-bit counter.
  - resv_en && resv_ready && resv_addr!=0 -> increment that counter.
  - wb_en && wb_addr!=0 -> decrement that counter.
  - Both on the same register in the same cycle -> counter unchanged.
  - resv_en while resv_ready=0 is dropped with no state change; the requester must retry.
  - wb_en on a counter at 0 -> data is still written, the counter stays 0, err_underflow is set until reset.
- rd_busy[i] = counter[rd_addr_i] != 0, except it reads 0 when all of these hold this cycle:
  - counter==1
  - wb_en targets that register
  - no same-cycle reservation of it
  
  In that case the read is satisfied by forwarding.
- resv_ready = counter[resv_addr] != max; it is combinational. Address 0 always reads ready.
- Port A writes never touch counters. A port-A write to a busy register is legal; data is overwritten and the counter is kept.
- Trace: for each committed write to a nonzero register, print "time@pc: $reg <= data", where pc is wa_pc or wb_pc, reg is decimal and data is hex.
- Latency: reads and status are 0-cycle combinational; writes and reservations are visible in stored state 1 cycle later.

Decomposition:
- Shared package:
  - default DATA_W/ADDR_W
  - zero-register constant
  - trace format string
  - helper function for packed-port slicing
- Natural sub-module: grf_scoreboard.
  - Contains the counter array, resv_ready, the rd_busy base, and err_underflow.
  - The top level holds the storage, forwarding and trace.

Test Plan:
- Reset, then write A $3<=0x12345678; next cycle read $3 on both ports -> 0x12345678, busy=0; trace line printed.
- Same cycle: wa ($5<=0xAAAA) and wb ($5<=0xBBBB), with read port 0 on $5 -> rd_data=0xAAAA. Next cycle $5=0xAAAA; traces print B then A.
- Reserve $8 (resv_ready=1) -> next cycle rd_busy=1 on $8. Cycle with wb_en $8=0x55 and read $8 -> busy=0, data=0x55. Next cycle counter=0.
- CNT_W=2: reserve $9 three times -> resv_ready=0. A fourth resv_en is dropped. Three wb writes are needed to clear busy.
- wb_en on $10 with no reservation -> $10 is written, err_underflow=1 and stays 1 until reset. Write/reserve $0 -> reads 0, no trace, not busy.
- Reset asserted mid-operation while wa_en and resv_en are active -> all registers and counters are 0 next cycle, no trace, err_underflow cleared.
